// File: rtl/data_mem_responder_if.sv
// Core-side data memory bus: word address, write data and write strobe in;
// zero-latency read data, GPIO contents and the access-fault pulse out.
interface data_mem_responder_if;
  // No valid/ready pair: every rising clk edge is a transaction. RAM_IN_WRITE=1
  // commits a write on that edge. RAM_OUT always reflects the current
  // RAM_IN_ADDRESS, and the core captures it on the next edge. The responder
  // never stalls.
  logic [31:0] RAM_IN_ADDRESS;
  logic [31:0] RAM_IN_DATA;
  logic        RAM_IN_WRITE;
  logic [31:0] RAM_OUT;
  logic [31:0] gpio_out;
  logic        access_fault;

  modport master (
    output RAM_IN_ADDRESS, RAM_IN_DATA, RAM_IN_WRITE,
    input  RAM_OUT, gpio_out, access_fault
  );

  modport slave (
    input  RAM_IN_ADDRESS, RAM_IN_DATA, RAM_IN_WRITE,
    output RAM_OUT, gpio_out, access_fault
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a small MMIO block (GPIO, free-running cycle
// counter, unmapped-write fault counter) and a zero-latency combinational read port.
module data_mem_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
  input logic clk,
  input logic clr,
  data_mem_responder_if.slave bus
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   gpio_q, gpio_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [7:0]    fault_cnt_q, fault_cnt_d;
  logic          access_fault_q, access_fault_d;

  logic          sel_ram, sel_gpio, sel_cycle, sel_faults, sel_unmapped;
  logic [AW-1:0] ram_idx;

  // Full 32-bit compares, so addresses at or above DEPTH never alias into RAM.
  always_comb begin
    sel_ram      = (bus.RAM_IN_ADDRESS < DEPTH_W);
    sel_gpio     = (bus.RAM_IN_ADDRESS == MMIO_BASE);
    sel_cycle    = (bus.RAM_IN_ADDRESS == MMIO_BASE + 32'd1);
    sel_faults   = (bus.RAM_IN_ADDRESS == MMIO_BASE + 32'd2);
    sel_unmapped = !(sel_ram || sel_gpio || sel_cycle || sel_faults);
  end

  assign ram_idx = bus.RAM_IN_ADDRESS[AW-1:0];

  // RAM has no reset value. clr only blocks writes while it is held.
  always_ff @(posedge clk or posedge clr) begin
    if (!clr) begin
      if (bus.RAM_IN_WRITE && sel_ram) mem_q[ram_idx] <= bus.RAM_IN_DATA;
    end
  end

  always_comb begin
    gpio_d         = gpio_q;
    cycle_d        = cycle_q + 32'd1;
    fault_cnt_d    = fault_cnt_q;
    access_fault_d = bus.RAM_IN_WRITE && sel_unmapped;
    if (bus.RAM_IN_WRITE) begin
      if (sel_gpio)  gpio_d  = bus.RAM_IN_DATA;
      if (sel_cycle) cycle_d = bus.RAM_IN_DATA;
      if (sel_faults) begin
        fault_cnt_d = 8'h00;
      end else if (sel_unmapped && fault_cnt_q != 8'hFF) begin
        fault_cnt_d = fault_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      gpio_q         <= 32'h0;
      cycle_q        <= 32'h0;
      fault_cnt_q    <= 8'h0;
      access_fault_q <= 1'b0;
    end else begin
      gpio_q         <= gpio_d;
      cycle_q        <= cycle_d;
      fault_cnt_q    <= fault_cnt_d;
      access_fault_q <= access_fault_d;
    end
  end

  // Reads show pre-edge state, which gives old-data on read-during-write.
  always_comb begin
    bus.RAM_OUT = 32'h0;
    if (sel_ram)         bus.RAM_OUT = mem_q[ram_idx];
    else if (sel_gpio)   bus.RAM_OUT = gpio_q;
    else if (sel_cycle)  bus.RAM_OUT = cycle_q;
    else if (sel_faults) bus.RAM_OUT = {24'h0, fault_cnt_q};
  end

  assign bus.gpio_out     = gpio_q;
  assign bus.access_fault = access_fault_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a vector table for single-cycle
// behaviour plus hand sequences for reset, cycle wrap, fault saturation and retention.
module tb_data_mem_responder;
  localparam logic [31:0] MB = 32'h0000_1000;

  logic clk = 1'b0;
  logic clr = 1'b1;
  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH(256), .MMIO_BASE(MB)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_af;
  } vec_t;

  vec_t vecs [18];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus.RAM_IN_WRITE   = we;
    bus.RAM_IN_ADDRESS = addr;
    bus.RAM_IN_DATA    = data;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0);

    // Table: mem[5], mem[0], mem[255] are written before being checked.
    vecs[0]  = '{1'b1, 32'd0,        32'h0000_0000, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 32'd5,        32'h1111_1111, 1'b0, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, 32'd5,        32'hDEAD_BEEF, 1'b1, 32'h1111_1111, 1'b0};
    vecs[3]  = '{1'b0, 32'd5,        32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'd256,      32'h0,         1'b1, 32'h0,         1'b0};
    vecs[5]  = '{1'b1, 32'd256,      32'h0000_0055, 1'b1, 32'h0,         1'b1};
    vecs[6]  = '{1'b0, 32'd0,        32'h0,         1'b1, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, MB + 32'd2,   32'h0,         1'b1, 32'h1,         1'b0};
    vecs[8]  = '{1'b1, MB,           32'h0000_00A5, 1'b1, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, MB,           32'h0,         1'b1, 32'h0000_00A5, 1'b0};
    vecs[10] = '{1'b1, MB + 32'd2,   32'h0001_2345, 1'b1, 32'h1,         1'b0};
    vecs[11] = '{1'b0, MB + 32'd2,   32'h0,         1'b1, 32'h0,         1'b0};
    vecs[12] = '{1'b0, MB + 32'd3,   32'h0,         1'b1, 32'h0,         1'b0};
    vecs[13] = '{1'b1, 32'd255,      32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
    vecs[14] = '{1'b0, 32'd255,      32'h0,         1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[15] = '{1'b1, 32'hFFFF_FFFF, 32'h7,        1'b1, 32'h0,         1'b1};
    vecs[16] = '{1'b0, MB + 32'd2,   32'h0,         1'b1, 32'h1,         1'b0};
    vecs[17] = '{1'b1, MB + 32'd2,   32'h0,         1'b1, 32'h1,         1'b0};

    // Reset state while clr is held.
    #1;
    check("rst_gpio", bus.gpio_out, 32'h0);
    check("rst_af", {31'h0, bus.access_fault}, 32'h0);
    drive(1'b0, MB + 32'd2, 32'h0);
    #1 check("rst_faults", bus.RAM_OUT, 32'h0);
    repeat (2) @(negedge clk);
    drive(1'b0, MB + 32'd1, 32'h0);
    clr = 1'b0;
    #1 check("cycle_at_release", bus.RAM_OUT, 32'h0);
    @(posedge clk); #1;
    check("cycle_after_release", bus.RAM_OUT, 32'h1);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].addr, vecs[i].data);
      #1;
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), bus.RAM_OUT, vecs[i].exp_rd);
      @(posedge clk); #1;
      check($sformatf("vec%0d_af", i), {31'h0, bus.access_fault}, {31'h0, vecs[i].exp_af});
    end
    check("gpio_out_after_write", bus.gpio_out, 32'h0000_00A5);

    // CYCLE load then wrap.
    @(negedge clk);
    drive(1'b1, MB + 32'd1, 32'hFFFF_FFFE);
    @(negedge clk);
    drive(1'b0, MB + 32'd1, 32'h0);
    #1 check("cycle_load", bus.RAM_OUT, 32'hFFFF_FFFE);
    @(negedge clk); #1 check("cycle_max", bus.RAM_OUT, 32'hFFFF_FFFF);
    @(negedge clk); #1 check("cycle_wrap", bus.RAM_OUT, 32'h0);

    // 300 unmapped writes: pulse held high, counter saturates.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h0000_2000, 32'(i));
      @(posedge clk); #1;
      check("sat_af_high", {31'h0, bus.access_fault}, 32'h1);
    end
    @(negedge clk);
    drive(1'b0, MB + 32'd2, 32'h0);
    #1 check("sat_faults", bus.RAM_OUT, 32'h0000_00FF);
    @(posedge clk); #1 check("sat_af_drop", {31'h0, bus.access_fault}, 32'h0);
    check("sat_gpio_kept", bus.gpio_out, 32'h0000_00A5);
    @(negedge clk);
    drive(1'b0, 32'd5, 32'h0);
    #1 check("sat_ram_kept", bus.RAM_OUT, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0000_2000, 32'h0);
    #1 check("unmapped_read", bus.RAM_OUT, 32'h0);

    // Fault clear.
    @(negedge clk);
    drive(1'b1, MB + 32'd2, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1'b0, MB + 32'd2, 32'h0);
    #1 check("clear_faults", bus.RAM_OUT, 32'h0);
    check("clear_af", {31'h0, bus.access_fault}, 32'h0);

    // Reset retention: RAM survives clr, MMIO state does not, writes under clr ignored.
    @(negedge clk); drive(1'b1, 32'd3, 32'h1234_5678);
    @(negedge clk); drive(1'b1, MB, 32'h0000_0077);
    @(negedge clk); drive(1'b1, 32'h0000_2000, 32'h0);
    @(negedge clk); drive(1'b0, MB + 32'd2, 32'h0);
    #1 check("pre_clr_faults", bus.RAM_OUT, 32'h1);
    check("pre_clr_gpio", bus.gpio_out, 32'h0000_0077);
    drive(1'b0, 32'd3, 32'h0);
    #1 clr = 1'b1;
    #1;
    check("clr_gpio_async", bus.gpio_out, 32'h0);
    check("clr_af_async", {31'h0, bus.access_fault}, 32'h0);
    check("clr_mem3_kept", bus.RAM_OUT, 32'h1234_5678);
    @(negedge clk); drive(1'b0, MB + 32'd1, 32'h0);
    #1 check("clr_cycle", bus.RAM_OUT, 32'h0);
    @(negedge clk); drive(1'b0, MB + 32'd2, 32'h0);
    #1 check("clr_faults", bus.RAM_OUT, 32'h0);
    @(negedge clk); drive(1'b1, 32'd3, 32'h0);
    @(negedge clk); drive(1'b1, MB, 32'h0000_0099);
    @(negedge clk); drive(1'b0, 32'd3, 32'h0);
    #1 check("clr_write_ignored_ram", bus.RAM_OUT, 32'h1234_5678);
    check("clr_write_ignored_gpio", bus.gpio_out, 32'h0);
    drive(1'b0, MB + 32'd1, 32'h0);
    clr = 1'b0;
    #1 check("rerelease_cycle0", bus.RAM_OUT, 32'h0);
    @(posedge clk); #1 check("rerelease_cycle1", bus.RAM_OUT, 32'h1);
    @(negedge clk); drive(1'b0, 32'd3, 32'h0);
    #1 check("post_clr_mem3", bus.RAM_OUT, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit RAM words (power of two, 16..1024).
REQ-002 SHALL have parameter MMIO_BASE, default 32'h0000_1000, meaning word address of the first MMIO register (must be >= DEPTH).
REQ-003 SHALL have port clk  input  1  the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port clr  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port RAM_IN_ADDRESS  input  32  word address from the core's MEM stage.
REQ-006 SHALL have port RAM_IN_DATA  input  32  write data from the core.
REQ-007 SHALL have port RAM_IN_WRITE  input  1  write strobe from the core, sampled at the rising clk edge.
REQ-008 SHALL have port RAM_OUT  output  32  read data, combinational from the current address and state.
REQ-009 SHALL have port gpio_out  output  32  GPIO register contents.
REQ-010 SHALL have port access_fault  output  1  registered one-cycle pulse flagging an unmapped write.

Function
REQ-011 SHALL decode addresses as word addresses (no byte lanes):
- 0..DEPTH-1 = RAM
- MMIO_BASE+0 = GPIO
- MMIO_BASE+1 = CYCLE
- MMIO_BASE+2 = FAULTS
- all other addresses = unmapped.
REQ-012 SHALL drive RAM_OUT in the same cycle the address is presented (zero-latency read), because the core captures RAM_OUT at the next edge.
REQ-013 SHALL return the following on RAM_OUT by region:
- RAM: mem[addr]
- GPIO: gpio_out
- CYCLE: cycle counter
- FAULTS: {24'h0, fault_count}
- unmapped: 32'h0000_0000.
REQ-014 SHALL write RAM_IN_DATA into the decoded target at the rising edge when RAM_IN_WRITE=1.
REQ-015 SHALL treat RAM_IN_WRITE=0 as a pure read with no state change other than the cycle counter.
REQ-016 SHALL, on a read-during-write to the same address, show the old value on RAM_OUT during the write cycle and the new value from the next cycle onward.
REQ-017 SHALL make the GPIO register read/write; gpio_out updates at the write edge.
REQ-018 SHALL increment CYCLE by 1 every clk edge while clr=0, wrapping 32'hFFFF_FFFF -> 0.
REQ-019 SHALL, on a write to CYCLE, load RAM_IN_DATA and override that edge's increment; the next edge increments from the loaded value.
REQ-020 SHALL, on each unmapped write, increment fault_count (8-bit), saturating at 8'hFF with no wrap.
REQ-021 SHALL, on any write to FAULTS, clear fault_count to 0, regardless of the data written.
REQ-022 SHALL set access_fault=1 for exactly the one cycle following an unmapped write edge, and 0 otherwise; back-to-back unmapped writes hold it high continuously.
REQ-023 SHALL ignore unmapped writes for all other state; RAM, GPIO and CYCLE are unaffected.
REQ-024 SHALL ignore X/Z-free address bits above the decoded range only via the decode of REQ-011 (no aliasing: address DEPTH is unmapped, not mem[0]).

Reset
REQ-025 SHALL, while clr=1, asynchronously force gpio_out=0, CYCLE=0, fault_count=0 and access_fault=0.
REQ-026 SHALL NOT reset RAM contents; they are retained across clr, and power-up contents are undefined.
REQ-027 SHALL ignore writes on edges where clr=1.
REQ-028 SHALL resume counting on the first clk edge after clr deasserts, so CYCLE reads 1 one cycle after release.
REQ-029 SHALL keep RAM_OUT combinational during reset; MMIO reads return reset values.

Verification
REQ-030 SHALL cover RAM write/read: write 32'hDEAD_BEEF to addr 5 -> same cycle RAM_OUT = old mem[5]; next cycle RAM_OUT = 32'hDEAD_BEEF; addr DEPTH reads 0.
REQ-031 SHALL cover GPIO: write 32'h0000_00A5 to MMIO_BASE -> gpio_out = 32'h0000_00A5 after the edge; read-back matches; clr pulse -> gpio_out = 0 immediately (async).
REQ-032 SHALL cover CYCLE wrap and load: write 32'hFFFF_FFFE to MMIO_BASE+1 -> reads FFFF_FFFE, then FFFF_FFFF, then 0000_0000 on successive cycles.
REQ-033 SHALL cover fault saturation: 300 consecutive writes to 32'h0000_2000 -> access_fault high throughout; FAULTS reads 8'hFF; RAM and GPIO unchanged.
REQ-034 SHALL cover fault clear: write any value to MMIO_BASE+2 -> FAULTS reads 0 next cycle and access_fault = 0.
REQ-035 SHALL cover reset retention: write mem[3]=32'h1234_5678, assert clr mid-run -> CYCLE, GPIO and FAULTS = 0, while mem[3] still reads 32'h1234_5678.
